// File: rtl/nv_csb_fifo_pkg.sv
// -----------------------------------------------------------------------------
// nv_csb_fifo_pkg
// Shared definitions for the CSB flop-RAM FIFO:
//   DEFAULT_WIDTH / DEFAULT_DEPTH - default payload width and entry count
//   ptr_inc()                     - pointer increment that wraps at any depth,
//                                   so DEPTH need not be a power of two
// -----------------------------------------------------------------------------
package nv_csb_fifo_pkg;

  localparam int DEFAULT_WIDTH = 34;
  localparam int DEFAULT_DEPTH = 2;

  // Next pointer value for a ring of 'depth' entries (0 .. depth-1).
  function automatic int ptr_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage : nv_csb_fifo_pkg

// File: rtl/nv_nvdla_csb_fifo_flopram_param_if.sv
// -----------------------------------------------------------------------------
// nv_nvdla_csb_fifo_flopram_param_if
// Write/read handshake bundle of the CSB FIFO.
//   wr_pvld / wr_prdy / wr_pd : producer side valid/ready/payload
//   rd_pvld / rd_prdy / rd_pd : consumer side valid/ready/payload
//   wr_count                  : entries accepted and not yet popped
// Modports:
//   slave  - the FIFO itself
//   master - the environment driving pushes and consuming pops
// WIDTH/DEPTH must match the parameters of the FIFO the bundle is bound to.
// -----------------------------------------------------------------------------
interface nv_nvdla_csb_fifo_flopram_param_if
  import nv_csb_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CW = $clog2(DEPTH + 1);

  logic             wr_pvld;
  logic             wr_prdy;
  logic [WIDTH-1:0] wr_pd;
  logic             rd_pvld;
  logic             rd_prdy;
  logic [WIDTH-1:0] rd_pd;
  logic [CW-1:0]    wr_count;

  modport slave (
    input  wr_pvld, wr_pd, rd_prdy,
    output wr_prdy, rd_pvld, rd_pd, wr_count
  );

  modport master (
    output wr_pvld, wr_pd, rd_prdy,
    input  wr_prdy, rd_pvld, rd_pd, wr_count
  );

endinterface : nv_nvdla_csb_fifo_flopram_param_if

// File: rtl/nv_csb_fifo_flopram.sv
// -----------------------------------------------------------------------------
// nv_csb_fifo_flopram
// DEPTH x WIDTH flop storage with one synchronous write port and one
// combinational read port.
//   clk  : write clock
//   we   : write enable
//   wa   : write address
//   di   : write data
//   ra   : read address
//   dout : storage[ra], combinational
// -----------------------------------------------------------------------------
module nv_csb_fifo_flopram
  import nv_csb_fifo_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] di,
  input  logic [AW-1:0]    ra,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy tracking guarantees no entry is
  // read before it is written, and a reset on the array would cost a
  // reset-tree load per bit for nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= di;
    end
  end

  assign dout = mem[ra];

endmodule : nv_csb_fifo_flopram

// File: rtl/nv_nvdla_csb_fifo_flopram_param.sv
// -----------------------------------------------------------------------------
// nv_nvdla_csb_fifo_flopram_param
// Width/depth-generic single-clock FIFO on flop storage for the CSB paths.
//   clk           : clock, all state on the rising edge
//   reset         : asynchronous, active-high reset
//   pwrbus_ram_pd : RAM power-control bus, kept for interface compatibility
//   bus (slave)   : wr_pvld/wr_prdy/wr_pd, rd_pvld/rd_prdy/rd_pd, wr_count
// Build option:
//   NV_CSB_FIFO_WR_RETIME_EN - register push/data for one cycle before the
//   storage write (2-cycle push-to-valid); otherwise storage is written on
//   the push edge (1-cycle push-to-valid).
// wr_count covers every accepted entry, including one held in the retime
// stage; rd_occ covers only entries already in storage and drives rd_pvld.
// -----------------------------------------------------------------------------
module nv_nvdla_csb_fifo_flopram_param
  import nv_csb_fifo_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [31:0]                             pwrbus_ram_pd,
  nv_nvdla_csb_fifo_flopram_param_if.slave        bus
);

  logic             push;
  logic             pop;
  logic             wr_prdy;
  logic             rd_pvld;
  logic             ram_we;
  logic [WIDTH-1:0] ram_di;
  logic [WIDTH-1:0] ram_dout;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    wr_count_q, wr_count_d;
  logic [CW-1:0]    rd_occ_q, rd_occ_d;

  // The power bus has no functional role here.
  logic pwrbus_unused;
  assign pwrbus_unused = ^pwrbus_ram_pd;

  // Ready comes only from the registered count, so a pop never opens a slot
  // for a push in the same cycle.
  assign wr_prdy = (wr_count_q != CW'(DEPTH));
  assign rd_pvld = (rd_occ_q != '0);
  assign push    = bus.wr_pvld & wr_prdy;
  assign pop     = rd_pvld & bus.rd_prdy;

  assign bus.wr_prdy  = wr_prdy;
  assign bus.rd_pvld  = rd_pvld;
  assign bus.rd_pd    = ram_dout;
  assign bus.wr_count = wr_count_q;

`ifdef NV_CSB_FIFO_WR_RETIME_EN
  logic             rt_vld_q, rt_vld_d;
  logic [WIDTH-1:0] rt_pd_q, rt_pd_d;

  always_comb begin
    rt_vld_d = push;
    rt_pd_d  = rt_pd_q;
    if (push) begin
      rt_pd_d = bus.wr_pd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rt_vld_q <= 1'b0;
    end else begin
      rt_vld_q <= rt_vld_d;
    end
  end

  // Payload is qualified by rt_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    rt_pd_q <= rt_pd_d;
  end

  assign ram_we = rt_vld_q;
  assign ram_di = rt_pd_q;
`else
  assign ram_we = push;
  assign ram_di = bus.wr_pd;
`endif

  // NOTE: every variable gets its hold value first so no path through the
  // block leaves it unassigned (which would infer a latch).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wr_count_d = wr_count_q;
    rd_occ_d   = rd_occ_q;

    if (ram_we) begin
      wr_ptr_d = AW'(ptr_inc(int'(wr_ptr_q), DEPTH));
    end
    if (pop) begin
      rd_ptr_d = AW'(ptr_inc(int'(rd_ptr_q), DEPTH));
    end

    case ({push, pop})
      2'b10:   wr_count_d = wr_count_q + CW'(1);
      2'b01:   wr_count_d = wr_count_q - CW'(1);
      default: wr_count_d = wr_count_q;
    endcase

    case ({ram_we, pop})
      2'b10:   rd_occ_d = rd_occ_q + CW'(1);
      2'b01:   rd_occ_d = rd_occ_q - CW'(1);
      default: rd_occ_d = rd_occ_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_count_q <= '0;
      rd_occ_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_count_q <= wr_count_d;
      rd_occ_q   <= rd_occ_d;
    end
  end

  nv_csb_fifo_flopram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .wa   (wr_ptr_q),
    .di   (ram_di),
    .ra   (rd_ptr_q),
    .dout (ram_dout)
  );

endmodule : nv_nvdla_csb_fifo_flopram_param

// File: doc/nv_nvdla_csb_fifo_flopram_param.md
# nv_nvdla_csb_fifo_flopram_param

Parametrised single-clock FIFO for the CSB master request/response paths, built on a flop-register storage array with an optional write-data retime stage. Replaces fixed-size 2-entry flop RAMs with a width/depth-generic buffer. Adds a valid/ready handshake on both sides, pointer management, occupancy reporting and full/empty flow control. Sits between the CSB master and the falcon/client interfaces wherever a small elastic buffer is needed.

## Interface
- WIDTH, 34, payload width in bits (>=1)
- DEPTH, 2, number of storage entries (>=2, any integer, not restricted to powers of two)
- AW, $clog2(DEPTH), pointer width (derived; not to be overridden)
- CW, $clog2(DEPTH+1), occupancy count width (derived)
- clk  input  1  single clock; all state on rising edge
- reset  input  1  asynchronous, active-high reset
- pwrbus_ram_pd  input  32  RAM power-control bus; carried for interface compatibility, no functional effect
- wr_pvld  input  1  write request valid
- wr_prdy  output  1  write ready; FIFO can accept an entry this cycle
- wr_pd  input  WIDTH  write payload
- rd_pvld  output  1  read data valid
- rd_prdy  input  1  read consumer ready
- rd_pd  output  WIDTH  read payload
- wr_count  output  CW  entries accepted and not yet popped (includes in-flight retime entry)

## Operation
- Push = wr_pvld & wr_prdy; pop = rd_pvld & rd_prdy.
- wr_prdy = (wr_count != DEPTH), combinational from a registered count. wr_pvld while wr_prdy=0 is ignored; data is not captured.
- The write pointer advances on each RAM write. The read pointer advances on each pop. Both wrap from DEPTH-1 to 0.
- Storage: DEPTH x WIDTH flops, written only at the entry addressed by the write pointer. Storage is not reset.
- rd_pd = storage[rd_ptr], a combinational mux. Its value is don't-care while rd_pvld=0.
- rd_pvld = (rd_occ != 0), where rd_occ counts entries resident in storage.
- wr_count: +1 on push, -1 on pop, unchanged on both or neither. It never exceeds DEPTH and never underflows.
- Full FIFO with a pop in the same cycle: wr_prdy stays 0 that cycle. No combinational pop-to-push path. The freed slot is visible the next cycle.
- Empty FIFO with a push: no bypass to the read side. rd_pvld rises after the write latency (see Timing).
- Reset, asynchronous at any time:
  - Pointers, wr_count, rd_occ and the retime valid flag are cleared.
  - Any in-flight entry is dropped.
  - Outputs while and after reset: wr_prdy=1, rd_pvld=0, wr_count=0.

## Timing
- With retime enabled: push at edge N loads the retime register. Storage is written at edge N+1. rd_pvld is 1 in the cycle after edge N+1 (2-cycle push-to-valid).
- With retime disabled: storage is written at edge N. rd_pvld is 1 after edge N (1-cycle push-to-valid).
- A pop at edge M updates rd_ptr, rd_occ and wr_count at M. The next entry is presented in the same cycle after M if one is resident.
- Sustained throughput is 1 push and 1 pop per cycle once the FIFO is neither full nor empty.

## Configuration
- Macro: NV_CSB_FIFO_WR_RETIME_EN.
- Defined: wr_pd/push are registered into a retime stage (data plus valid) before the storage write. This adds one cycle of write latency and cuts the input-to-storage timing path. wr_count includes the entry held in the retime stage, so full is never overrun.
- Undefined: the storage write happens directly on push. The retime stage is absent and the latency is 1 cycle.
- Port list is identical in both builds.

## Structure
- Package nv_csb_fifo_pkg holds:
  - default WIDTH/DEPTH constants;
  - a pointer-increment-with-wrap function, parametrised by depth.
- Sub-module nv_csb_fifo_flopram: the storage array with one write port (we, wa, di) and a combinational read mux (ra, dout), parametrised by WIDTH/DEPTH.
- The top level holds the pointers, counters, handshake and the optional retime stage.

## Test plan
- Reset then idle: wr_prdy=1, rd_pvld=0, wr_count=0. Assert reset mid-stream with 2 entries held: the same values appear immediately and no stale data is popped afterwards.
- DEPTH=2, WIDTH=34, retime on: push 0x2_AAAA_5555 at cycle 0 -> rd_pvld first 1 at cycle 2 with rd_pd=0x2_AAAA_5555. Retime off: valid at cycle 1.
- Fill DEPTH=5 with values 1..5 while rd_prdy=0 -> wr_count=5, wr_prdy=0. A 6th wr_pvld is ignored. Popping yields 1..5 in order.
- Full with a simultaneous push attempt and pop: that cycle wr_count goes 5->4 and the push is not taken. wr_prdy=1 the next cycle.
- Continuous push/pop of 3*DEPTH incrementing values on DEPTH=3 -> in-order output across pointer wrap, wr_count stable, no bubbles after fill.
